// File: rtl/lsu_pkg.sv
// LSU shared types: FSM states, RISC-V funct3 width codes
// and an access-size helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Bytes touched by an access, from funct3[1:0].
  function automatic logic [2:0] acc_size(
    input logic [1:0] sz
  );
    logic [2:0] r;
    unique case (sz)
      2'b00:   r = 3'd1;
      2'b01:   r = 3'd2;
      default: r = 3'd4;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: load extract + extend
// and store merge into an existing RAM word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [4:0]  bit_off;

  assign bit_off = {byte_off, 3'b000};

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    lane_b = rdata[bit_off +: 8];
    lane_h = byte_off[1] ? rdata[31:16]
                         : rdata[15:0];
  end

  // Sign- or zero-extend the selected lane.
  always_comb begin
    load_data = rdata;
    unique case (1'b1)
      (funct3 == F3_LB):
        load_data = {{24{lane_b[7]}}, lane_b};
      (funct3 == F3_LBU):
        load_data = {24'h0, lane_b};
      (funct3 == F3_LH):
        load_data = {{16{lane_h[15]}}, lane_h};
      (funct3 == F3_LHU):
        load_data = {16'h0, lane_h};
      default:
        load_data = rdata;
    endcase
  end

  // Overlay store lanes; untouched bytes keep RAM value.
  always_comb begin
    merged = rdata;
    unique case (1'b1)
      (funct3 == F3_SB):
        merged[bit_off +: 8] = wdata[7:0];
      (funct3 == F3_SH):
        if (byte_off[1])
          merged[31:16] = wdata[15:0];
        else
          merged[15:0] = wdata[15:0];
      default:
        merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit master onto a single-port word RAM.
// Sub-word stores are done as read-modify-write.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  state_t state_q;
  state_t state_d;

  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [2:0]  acc_sz;
  logic [32:0] end_addr;
  logic        oor;
  logic        mis;
  logic        bad_f3;
  logic        acc_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Classify the incoming request as legal or not.
  always_comb begin
    acc_sz   = acc_size(req_funct3[1:0]);
    end_addr = {1'b0, req_addr}
             + {30'h0, acc_sz};
    oor      = end_addr > 33'(MEM_BYTES);
    mis      = ((req_funct3[1:0] == 2'b01)
                && req_addr[0])
            || ((req_funct3[1:0] == 2'b10)
                && (req_addr[1:0] != 2'b00));
    if (req_we)
      bad_f3 = req_funct3 > F3_SW;
    else
      bad_f3 = (req_funct3 == 3'b011)
            || (req_funct3 == 3'b110)
            || (req_funct3 == 3'b111);
    acc_err  = oor || mis || bad_f3;
  end

  lsu_align u_align (
    .funct3    (f3_q),
    .byte_off  (off_q),
    .rdata     (mem_rdata),
    .wdata     (mem_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (req_valid) begin
          if (acc_err)
            state_d = S_RESP;
          else if (!req_we)
            state_d = S_LOAD;
          else if (req_funct3 == F3_SW)
            state_d = S_WRITE;
          else
            state_d = S_RMW_READ;
        end
      S_LOAD:     state_d = S_RESP;
      S_RMW_READ: state_d = S_WRITE;
      S_WRITE:    state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Handshake and write strobe from state.
  always_comb begin
    req_ready  = state_q == S_IDLE;
    resp_valid = state_q == S_RESP;
    mem_wr     = state_q == S_WRITE;
  end

  // Request latch, RAM address/data and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q       <= '0;
      off_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (req_valid) begin
            f3_q     <= req_funct3;
            off_q    <= req_addr[1:0];
            mem_addr <= {req_addr[31:2], 2'b00};
            if (req_we)
              mem_wdata <= req_wdata;
            if (acc_err) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end
          end
        S_LOAD: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
        end
        S_RMW_READ:
          mem_wdata <= merged;
        S_WRITE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
